// File: rtl/bus_xfr_pkg.sv
// Shared constants and types for the bus transfer receive buffer.
//   DATA_W / MAX_BUFF_SIZE / AFULL_LEVEL : default sizing
//   data_t : one data word, cnt_t : occupancy (0..MAX_BUFF_SIZE)
package bus_xfr_pkg;

    localparam int unsigned DATA_W        = 32;
    localparam int unsigned MAX_BUFF_SIZE = 1024;
    localparam int unsigned AFULL_LEVEL   = 1020;
    localparam int unsigned ADDR_W        = $clog2(MAX_BUFF_SIZE);

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W:0]   cnt_t;

endpackage

// File: rtl/bus_xfr_rx_buffer_if.sv
// Receive buffer bus: write/read requests in, read data and status out.
//   master : the side issuing wr/rd/err_clr (receiver + write source)
//   slave  : the buffer itself
interface bus_xfr_rx_buffer_if #(
    parameter int unsigned DATA_W        = bus_xfr_pkg::DATA_W,
    parameter int unsigned MAX_BUFF_SIZE = bus_xfr_pkg::MAX_BUFF_SIZE
);
    localparam int unsigned CNT_W = $clog2(MAX_BUFF_SIZE) + 1;

    logic              wr;
    logic [DATA_W-1:0] wdata;
    logic              rd;
    logic              err_clr;
    logic [DATA_W-1:0] rdata;
    logic              rdata_valid;
    logic [CNT_W-1:0]  count;
    logic              empty;
    logic              full;
    logic              almost_full;
    logic              overflow_err;
    logic              underflow_err;

    modport master (
        output wr, wdata, rd, err_clr,
        input  rdata, rdata_valid, count, empty, full, almost_full,
               overflow_err, underflow_err
    );

    modport slave (
        input  wr, wdata, rd, err_clr,
        output rdata, rdata_valid, count, empty, full, almost_full,
               overflow_err, underflow_err
    );

endinterface

// File: rtl/bus_xfr_buff_mem.sv
// Simple dual-port storage array: one write port, one registered read port.
// No reset; read data holds until the next read enable.
//   clk                         : clock
//   wr_en_i/wr_addr_i/wr_data_i : write port
//   rd_en_i/rd_addr_i           : read request
//   rd_data_o                   : read data, one cycle after rd_en_i
module bus_xfr_buff_mem #(
    parameter int unsigned DATA_W = bus_xfr_pkg::DATA_W,
    parameter int unsigned DEPTH  = bus_xfr_pkg::MAX_BUFF_SIZE,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Same-address read and write returns the old word (full + rd + wr case).
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_o <= mem_q[rd_addr_i];
        end
    end

endmodule

// File: rtl/bus_xfr_rx_buffer.sv
// Receive-side FIFO buffer: in-order storage, 1-cycle read latency,
// occupancy/full/empty/almost_full status and sticky over/underflow errors.
//   clk, reset_n : clock, async active-low reset
//   bus (slave)  : wr/wdata/rd/err_clr in; rdata/rdata_valid/count/empty/
//                  full/almost_full/overflow_err/underflow_err out
module bus_xfr_rx_buffer #(
    parameter int unsigned DATA_W        = bus_xfr_pkg::DATA_W,
    parameter int unsigned MAX_BUFF_SIZE = bus_xfr_pkg::MAX_BUFF_SIZE,
    parameter int unsigned AFULL_LEVEL   = bus_xfr_pkg::AFULL_LEVEL
) (
    input  logic               clk,
    input  logic               reset_n,
    bus_xfr_rx_buffer_if.slave bus
);

    localparam int unsigned ADDR_W = $clog2(MAX_BUFF_SIZE);
    localparam int unsigned CNT_W  = ADDR_W + 1;

    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              empty_q, full_q, afull_q;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;
    logic              valid_q;
    logic              rdata_seen_q;
    logic              rd_acc, wr_acc;
    logic [DATA_W-1:0] mem_rdata;

    // Acceptance, pointer/count next state and sticky error next state.
    always_comb begin
        rd_acc  = 1'b0;
        wr_acc  = 1'b0;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;

        rd_acc = bus.rd & ~empty_q;
        // A write on full is fine when a pop frees a slot in the same cycle.
        wr_acc = bus.wr & (~full_q | rd_acc);

        if (wr_acc) begin
            wptr_d = wptr_q + ADDR_W'(1);
        end
        if (rd_acc) begin
            rptr_d = rptr_q + ADDR_W'(1);
        end
        count_d = count_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);

        // Clear first so a same-cycle error event wins.
        if (bus.err_clr) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
        if (bus.wr & ~wr_acc) begin
            ovf_d = 1'b1;
        end
        if (bus.rd & ~rd_acc) begin
            udf_d = 1'b1;
        end
    end

    // State and status registers; flags derived from next count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
            empty_q      <= 1'b1;
            full_q       <= 1'b0;
            afull_q      <= 1'b0;
            ovf_q        <= 1'b0;
            udf_q        <= 1'b0;
            valid_q      <= 1'b0;
            rdata_seen_q <= 1'b0;
        end else begin
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            count_q      <= count_d;
            empty_q      <= (count_d == '0);
            full_q       <= (count_d == CNT_W'(MAX_BUFF_SIZE));
            afull_q      <= (count_d >= CNT_W'(AFULL_LEVEL));
            ovf_q        <= ovf_d;
            udf_q        <= udf_d;
            valid_q      <= rd_acc;
            rdata_seen_q <= rdata_seen_q | rd_acc;
        end
    end

    bus_xfr_buff_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (MAX_BUFF_SIZE)
    ) u_mem (
        .clk       (clk),
        .wr_en_i   (wr_acc),
        .wr_addr_i (wptr_q),
        .wr_data_i (bus.wdata),
        .rd_en_i   (rd_acc),
        .rd_addr_i (rptr_q),
        .rd_data_o (mem_rdata)
    );

    // The storage has no reset, so rdata reads as zero until the first pop
    // after reset; afterwards the RAM output register holds the last word.
    assign bus.rdata         = rdata_seen_q ? mem_rdata : '0;
    assign bus.rdata_valid   = valid_q;
    assign bus.count         = count_q;
    assign bus.empty         = empty_q;
    assign bus.full          = full_q;
    assign bus.almost_full   = afull_q;
    assign bus.overflow_err  = ovf_q;
    assign bus.underflow_err = udf_q;

endmodule

// File: tb/tb_bus_xfr_rx_buffer.sv
// Self-checking bench for bus_xfr_rx_buffer against a queue-based model.
module tb_bus_xfr_rx_buffer;
    import bus_xfr_pkg::*;

    localparam int unsigned DEPTH = MAX_BUFF_SIZE;
    localparam int unsigned AFULL = AFULL_LEVEL;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    bus_xfr_rx_buffer_if #(.DATA_W(DATA_W), .MAX_BUFF_SIZE(DEPTH)) bus ();

    bus_xfr_rx_buffer #(
        .DATA_W        (DATA_W),
        .MAX_BUFF_SIZE (DEPTH),
        .AFULL_LEVEL   (AFULL)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Reference model state
    data_t q[$];
    data_t exp_rdata;
    logic  exp_valid;
    logic  exp_ovf;
    logic  exp_udf;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        cnt_t c;
        c = cnt_t'(q.size());
        check("rdata",         64'(bus.rdata),         64'(exp_rdata));
        check("rdata_valid",   64'(bus.rdata_valid),   64'(exp_valid));
        check("count",         64'(bus.count),         64'(c));
        check("empty",         64'(bus.empty),         64'(q.size() == 0));
        check("full",          64'(bus.full),          64'(q.size() == DEPTH));
        check("almost_full",   64'(bus.almost_full),   64'(q.size() >= AFULL));
        check("overflow_err",  64'(bus.overflow_err),  64'(exp_ovf));
        check("underflow_err", 64'(bus.underflow_err), 64'(exp_udf));
    endtask

    task automatic model_reset();
        q.delete();
        exp_rdata = '0;
        exp_valid = 1'b0;
        exp_ovf   = 1'b0;
        exp_udf   = 1'b0;
    endtask

    // One clock: drive at negedge, update model at posedge, check just after.
    task automatic step(input logic w, input data_t wd, input logic r, input logic clr);
        bit rd_ok;
        bit wr_ok;
        @(negedge clk);
        bus.wr      = w;
        bus.wdata   = wd;
        bus.rd      = r;
        bus.err_clr = clr;
        @(posedge clk);
        rd_ok = r && (q.size() != 0);
        wr_ok = w && ((q.size() < DEPTH) || rd_ok);
        exp_valid = rd_ok;
        if (rd_ok) exp_rdata = q.pop_front();
        if (wr_ok) q.push_back(wd);
        exp_ovf = (w && !wr_ok) || (exp_ovf && !clr);
        exp_udf = (r && !rd_ok) || (exp_udf && !clr);
        #1;
        check_all();
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        int wp;
        int rp;
        reset_n     = 1'b0;
        bus.wr      = 1'b0;
        bus.wdata   = '0;
        bus.rd      = 1'b0;
        bus.err_clr = 1'b0;
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) idle();

        // Two directed words, back-to-back reads
        step(1'b1, 32'hC3A5_F0FA, 1'b0, 1'b0);
        step(1'b1, 32'h0000_0001, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        check("t2_first_word", 64'(bus.rdata), 64'h0000_0000_C3A5_F0FA);
        check("t2_count_1", 64'(bus.count), 64'd1);
        step(1'b0, '0, 1'b1, 1'b0);
        check("t2_second_word", 64'(bus.rdata), 64'h1);
        check("t2_empty", 64'(bus.empty), 64'd1);
        idle();

        // Fill with incrementing words (pointers start at 2, so this wraps)
        for (int i = 0; i < int'(DEPTH); i++) begin
            step(1'b1, data_t'(i), 1'b0, 1'b0);
            if (i == int'(AFULL) - 2) check("afull_below", 64'(bus.almost_full), 64'd0);
            if (i == int'(AFULL) - 1) check("afull_at_level", 64'(bus.almost_full), 64'd1);
        end
        check("full_at_depth", 64'(bus.full), 64'd1);
        step(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        check("ovf_on_full", 64'(bus.overflow_err), 64'd1);
        check("count_stays_full", 64'(bus.count), 64'(DEPTH));
        step(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < int'(DEPTH); i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            check("drain_order", 64'(bus.rdata), 64'(i));
        end
        idle();

        // Full with simultaneous wr+rd
        for (int i = 0; i < int'(DEPTH); i++) step(1'b1, data_t'($urandom), 1'b0, 1'b0);
        step(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
        check("wr_rd_full_count", 64'(bus.count), 64'(DEPTH));
        check("wr_rd_full_no_ovf", 64'(bus.overflow_err), 64'd0);
        for (int i = 0; i < int'(DEPTH); i++) step(1'b0, '0, 1'b1, 1'b0);
        check("deadbeef_last", 64'(bus.rdata), 64'h0000_0000_DEAD_BEEF);
        idle();

        // Read on empty with simultaneous write
        step(1'b1, 32'h5, 1'b1, 1'b0);
        check("udf_set", 64'(bus.underflow_err), 64'd1);
        check("udf_no_valid", 64'(bus.rdata_valid), 64'd0);
        check("udf_count_1", 64'(bus.count), 64'd1);
        step(1'b0, '0, 1'b0, 1'b1);
        check("udf_cleared", 64'(bus.underflow_err), 64'd0);
        step(1'b0, '0, 1'b1, 1'b0);
        check("read_five", 64'(bus.rdata), 64'h5);

        // Randomized traffic in phases of varying write/read bias
        for (int ph = 0; ph < 8; ph++) begin
            wp = int'($urandom_range(10, 90));
            rp = int'($urandom_range(10, 90));
            for (int i = 0; i < 500; i++) begin
                step(($urandom_range(0, 99) < 32'(wp)),
                     data_t'($urandom),
                     ($urandom_range(0, 99) < 32'(rp)),
                     ($urandom_range(0, 31) == 0));
            end
        end
        while (q.size() != 0) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);

        // Async reset landing right after a pop
        for (int i = 0; i < 3; i++) step(1'b1, data_t'(32'hA0 + i), 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        check("pre_reset_valid", 64'(bus.rdata_valid), 64'd1);
        @(negedge clk);
        bus.rd = 1'b1;
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_all();
        check("reset_drops_valid", 64'(bus.rdata_valid), 64'd0);
        check("reset_count", 64'(bus.count), 64'd0);
        @(negedge clk);
        bus.rd  = 1'b0;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) idle();
        check("post_reset_empty", 64'(bus.empty), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
